// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
//   Definitions shared by the memory-mapped I/O blocks (switch reader, LED
//   driver). It holds the byte-lane decode constants and the status word bit
//   positions, plus a helper that zero-extends a byte lane onto the bus.
//   It has no ports.
// ----------------------------------------------------------------------------
package io_pkg;

   // Lane select values; the LED block decodes the same addresses.
   localparam logic [1:0] SW_LANE0  = 2'b00;
   localparam logic [1:0] SW_LANE1  = 2'b01;
   localparam logic [1:0] SW_LANE2  = 2'b10;
   localparam logic [1:0] SW_STATUS = 2'b11;

   // Bit positions inside the status word.
   localparam int STATUS_PENDING_BIT = 0;
   localparam int STATUS_LEVEL_BIT   = 1;

   // Places a byte lane on the 16-bit read bus with the upper byte zero.
   function automatic logic [15:0] lane_word(input logic [7:0] b);
      return {8'h00, b};
   endfunction

endpackage

// File: rtl/switch_reader_debouncer.sv
// ----------------------------------------------------------------------------
// switch_reader_debouncer
//   Synchronises an asynchronous input vector with two flops, then accepts a
//   new value only after it has held steady for DEBOUNCE_CYCLES clocks. The
//   whole vector shares one counter, so a change on any bit restarts the wait.
//
//   Ports
//     clock     system clock
//     reset     asynchronous, active-high reset
//     raw_i     raw asynchronous input vector (WIDTH bits)
//     stable_o  debounced value (WIDTH bits), resets to 0
// ----------------------------------------------------------------------------
module switch_reader_debouncer #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw_i,
   output logic [WIDTH-1:0] stable_o
);

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // sync2_q is the synchronised vector. sync1_q is the sample that it takes
   // on the next edge. Comparing the two detects a change one cycle earlier
   // than adding a third "previous sample" register would. That earlier
   // detection gives the acceptance latency of DEBOUNCE_CYCLES+2 after an
   // input change.
   always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync1_q != sync2_q) begin
         cnt_d = '0;
      end else begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
         // Loads once per stable run. After this the counter saturates
         // above CNT_LOAD, so the register does not reload.
         if (cnt_q == CNT_LOAD) stable_d = sync2_q;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         cnt_q    <= '0;
         stable_q <= '0;
      end else begin
         sync1_q  <= raw_i;
         sync2_q  <= sync1_q;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable_o = stable_q;

endmodule

// File: rtl/switch_reader.sv
// ----------------------------------------------------------------------------
// switch_reader
//   CPU I/O-bus input peripheral. It debounces 24 board switches and a confirm
//   button, and shows the switches as three byte lanes. A status word holds
//   the button level and a sticky "confirm pressed" flag (pending). A status
//   read clears pending. When a new press arrives in the same cycle, the set
//   wins over the clear.
//
//   Build option: define SWITCH_IRQ_EN to add the irq output. irq is a
//   registered copy of pending.
//
//   Ports
//     clock        system clock
//     reset        asynchronous, active-high reset
//     SwitchCtrl   peripheral select from the address decoder
//     ioRead       CPU I/O read strobe
//     switchAddr   lane select: 00/01/10 switch bytes, 11 status
//     switches     raw board switches (24, asynchronous)
//     confirm_btn  raw confirm button (active-high, asynchronous, bouncy)
//     read_data    16-bit read data; zero when this block is not being read
//     irq          (SWITCH_IRQ_EN only) confirm-press interrupt, equals pending
// ----------------------------------------------------------------------------
module switch_reader
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        SwitchCtrl,
   input  logic        ioRead,
   input  logic [1:0]  switchAddr,
   input  logic [23:0] switches,
   input  logic        confirm_btn,
`ifdef SWITCH_IRQ_EN
   output logic        irq,
`endif
   output logic [15:0] read_data
);

   logic [23:0] sw_stable;
   logic        btn_stable;
   logic        btn_prev_q;
   logic        pending_q, pending_d;
   logic        rd_access;
   logic        status_rd;
   logic        btn_rise;

   switch_reader_debouncer #(
      .WIDTH          (24),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_sw_db (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (switches),
      .stable_o(sw_stable)
   );

   switch_reader_debouncer #(
      .WIDTH          (1),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_btn_db (
      .clock   (clock),
      .reset   (reset),
      .raw_i   (confirm_btn),
      .stable_o(btn_stable)
   );

   assign rd_access = SwitchCtrl & ioRead;
   assign status_rd = rd_access & (switchAddr == SW_STATUS);
   assign btn_rise  = btn_stable & ~btn_prev_q;

   // A read held over several cycles clears pending only once, because only
   // a new rising edge can set it again. Set has priority, so a press that
   // lands on a clearing read is kept.
   assign pending_d = btn_rise | (pending_q & ~status_rd);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_prev_q <= 1'b0;
         pending_q  <= 1'b0;
      end else begin
         btn_prev_q <= btn_stable;
         pending_q  <= pending_d;
      end
   end

`ifdef SWITCH_IRQ_EN
   assign irq = pending_q;
`endif

   // The read mux outputs zero when this block is not selected, so its
   // output can be ORed onto the shared read bus. A status read returns the
   // value of pending from before the clear.
   always_comb begin
      read_data = 16'h0000;
      if (rd_access) begin
         unique case (switchAddr)
            SW_LANE0: read_data = lane_word(sw_stable[7:0]);
            SW_LANE1: read_data = lane_word(sw_stable[15:8]);
            SW_LANE2: read_data = lane_word(sw_stable[23:16]);
            SW_STATUS: begin
               read_data[STATUS_PENDING_BIT] = pending_q;
               read_data[STATUS_LEVEL_BIT]   = btn_stable;
            end
            default: read_data = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_switch_reader.sv
module tb_switch_reader;

   localparam int DC = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        SwitchCtrl, ioRead;
   logic [1:0]  switchAddr;
   logic [23:0] switches;
   logic        confirm_btn;
   logic [15:0] read_data;
`ifdef SWITCH_IRQ_EN
   logic        irq;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];
   string       nm_q[$];

   typedef struct {
      logic        c;
      logic        r;
      logic [1:0]  a;
      logic [15:0] e;
      string       nm;
   } vec_t;
   vec_t tbl[9];

   switch_reader #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
      .clock      (clock),
      .reset      (reset),
      .SwitchCtrl (SwitchCtrl),
      .ioRead     (ioRead),
      .switchAddr (switchAddr),
      .switches   (switches),
      .confirm_btn(confirm_btn),
`ifdef SWITCH_IRQ_EN
      .irq        (irq),
`endif
      .read_data  (read_data)
   );

   always #5 clock = ~clock;

   // Advance one clock edge and leave the bus idle for the new cycle.
   task automatic tick();
      @(posedge clock);
      #1;
      SwitchCtrl = 1'b0;
      ioRead     = 1'b0;
      switchAddr = 2'b00;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drive a bus access, queue its expected data, then compare in mid-cycle.
   task automatic rd(input logic c, input logic r, input logic [1:0] a,
                     input logic [15:0] e, input string nm);
      logic [15:0] ex;
      string       n;
      SwitchCtrl = c;
      ioRead     = r;
      switchAddr = a;
      exp_q.push_back(e);
      nm_q.push_back(nm);
      #2;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         ex = exp_q.pop_front();
         n  = nm_q.pop_front();
         if (read_data !== ex) begin
            errors++;
            $display("FAIL %s: read_data=%h expected %h", n, read_data, ex);
         end
      end
   endtask

   task automatic chk_irq(input logic e, input string nm);
`ifdef SWITCH_IRQ_EN
      checks++;
      if (irq !== e) begin
         errors++;
         $display("FAIL %s: irq=%b expected %b", nm, irq, e);
      end
`else
      if (nm.len() < 0) $display("%b", e);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{1'b1, 1'b1, 2'b00, 16'h003C, "lane0"};
      tbl[1] = '{1'b1, 1'b1, 2'b01, 16'h00C3, "lane1"};
      tbl[2] = '{1'b1, 1'b1, 2'b10, 16'h00A5, "lane2"};
      tbl[3] = '{1'b1, 1'b1, 2'b11, 16'h0000, "status_idle"};
      tbl[4] = '{1'b0, 1'b1, 2'b00, 16'h0000, "nosel_lane0"};
      tbl[5] = '{1'b1, 1'b0, 2'b01, 16'h0000, "nord_lane1"};
      tbl[6] = '{1'b0, 1'b1, 2'b11, 16'h0000, "nosel_status"};
      tbl[7] = '{1'b1, 1'b0, 2'b10, 16'h0000, "nord_lane2"};
      tbl[8] = '{1'b0, 1'b0, 2'b11, 16'h0000, "idle_status"};

      reset = 1'b1; SwitchCtrl = 0; ioRead = 0; switchAddr = 0;
      switches = 24'h0; confirm_btn = 0;

      // Reset state.
      #3;
      rd(1, 1, 2'b00, 16'h0000, "rst_lane0");
      rd(1, 1, 2'b01, 16'h0000, "rst_lane1");
      rd(1, 1, 2'b10, 16'h0000, "rst_lane2");
      rd(1, 1, 2'b11, 16'h0000, "rst_status");
      chk_irq(1'b0, "rst_irq");
      tick();
      reset    = 1'b0;
      switches = 24'hA5C33C;

      // The value is not visible before DC+2 edges have passed.
      for (int k = 1; k < DC + 2; k++) begin
         tick();
         rd(1, 1, 2'(k % 3), 16'h0000, "pre_accept");
      end
      tick();
      rd(1, 1, 2'b00, 16'h003C, "accept_lane0");
      ticks(4);

      for (int i = 0; i < 9; i++) begin
         rd(tbl[i].c, tbl[i].r, tbl[i].a, tbl[i].e, tbl[i].nm);
         tick();
      end

      // A bit that toggles every 2 cycles never becomes stable.
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) switches[0] = ~switches[0];
         rd(1, 1, 2'b00, 16'h003C, "glitch_lane0");
         tick();
      end
      ticks(8);

      // Button press: it is accepted at edge DC+2, and pending is set one edge later.
      confirm_btn = 1'b1;
      ticks(DC + 3);
      chk_irq(1'b1, "press_irq");
      rd(0, 1, 2'b11, 16'h0000, "press_nosel");
      tick();
      rd(1, 0, 2'b11, 16'h0000, "press_nord");
      tick();
      rd(1, 1, 2'b11, 16'h0003, "press_status");
      tick();
      chk_irq(1'b0, "cleared_irq");
      rd(1, 1, 2'b11, 16'h0002, "press_status2");
      tick();
      rd(1, 1, 2'b11, 16'h0002, "press_status3");
      tick();
      confirm_btn = 1'b0;
      ticks(DC + 4);
      rd(1, 1, 2'b11, 16'h0000, "release_status");
      tick();

      // A status read in the same cycle as the rising edge: the read sees the old pending, and the set wins.
      confirm_btn = 1'b1;
      ticks(DC + 2);
      chk_irq(1'b0, "samecyc_irq0");
      rd(1, 1, 2'b11, 16'h0002, "samecyc_read");
      tick();
      chk_irq(1'b1, "samecyc_irq1");
      rd(1, 1, 2'b11, 16'h0003, "samecyc_next");
      tick();
      rd(1, 1, 2'b11, 16'h0002, "samecyc_after");
      tick();

      // Reset in the middle of debouncing a change; the button stays held.
      switches = 24'hFFFFFF;
      ticks(3);
      #2;
      reset = 1'b1;
      #1;
      rd(1, 1, 2'b00, 16'h0000, "midrst_lane0");
      rd(1, 1, 2'b01, 16'h0000, "midrst_lane1");
      rd(1, 1, 2'b10, 16'h0000, "midrst_lane2");
      rd(1, 1, 2'b11, 16'h0000, "midrst_status");
      chk_irq(1'b0, "midrst_irq");
      tick();
      reset = 1'b0;
      for (int k = 1; k < DC + 2; k++) begin
         tick();
         rd(1, 1, 2'b00, 16'h0000, "postrst_pre");
      end
      tick();
      rd(1, 1, 2'b00, 16'h00FF, "postrst_lane0");
      tick();
      chk_irq(1'b1, "postrst_irq");
      rd(1, 1, 2'b01, 16'h00FF, "postrst_lane1");
      tick();
      rd(1, 1, 2'b10, 16'h00FF, "postrst_lane2");
      tick();
      rd(1, 1, 2'b11, 16'h0003, "postrst_status");
      tick();
      rd(1, 1, 2'b11, 16'h0002, "postrst_status2");
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
